// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the hazard/stall controller: memory FSM states and default widths.
package hazard_ctrl_pkg;
   localparam int DEF_REG_W = 5;
   localparam int ST_W      = 2;

   typedef enum logic [ST_W-1:0] {
      M_IDLE = 2'd0,
      M_WAIT = 2'd1,
      M_DONE = 2'd2
   } mem_state_e;
endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle of the hazard/stall controller; slave = controller, master = pipeline.
interface hazard_stall_controller_if import hazard_ctrl_pkg::*; #(
   parameter int REG_W = DEF_REG_W
);
   logic             forwarding_enable;
   logic [REG_W-1:0] id_src1;
   logic [REG_W-1:0] id_src2;
   logic [REG_W-1:0] id_src3;
   logic             id_src2_used;
   logic             id_src3_used;
   logic [REG_W-1:0] exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [REG_W-1:0] mem_dest;
   logic             mem_wb_en;
   logic             branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             hazard_stall;
   logic             flush_if_id;
   logic             pipe_freeze;
   logic             mem_start;
   logic             mem_timeout;
   logic [ST_W-1:0]  mem_state;

   modport slave (
      input  forwarding_enable, id_src1, id_src2, id_src3, id_src2_used, id_src3_used,
      input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
      input  branch_taken, mem_req, mem_ready,
      output hazard_stall, flush_if_id, pipe_freeze, mem_start, mem_timeout, mem_state
   );

   modport master (
      output forwarding_enable, id_src1, id_src2, id_src3, id_src2_used, id_src3_used,
      output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
      output branch_taken, mem_req, mem_ready,
      input  hazard_stall, flush_if_id, pipe_freeze, mem_start, mem_timeout, mem_state
   );
endinterface

// File: rtl/hazard_stall_controller_mem_wait_fsm.sv
// MEM-stage SRAM wait sequencer: start pulse, whole-pipeline freeze, bounded wait, sticky timeout.
//
// state  | meaning
// M_IDLE | no access; a request starts one and freezes this cycle
// M_WAIT | waiting for mem_ready, pipeline frozen, timeout timer running
// M_DONE | access complete (or abandoned), pipeline advances one cycle
module mem_wait_fsm import hazard_ctrl_pkg::*; #(
   parameter int WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_req,
   input  logic            mem_ready,
   output logic            pipe_freeze,
   output logic            mem_start,
   output logic            mem_timeout,
   output logic [ST_W-1:0] mem_state
);
   localparam int            CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'((WAIT_MAX > 0) ? (WAIT_MAX - 1) : 0);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             freeze_raw, start_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= M_IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Timer counts down from WAIT_MAX-1; terminal count in the WAIT_MAX-th wait cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      freeze_raw = 1'b0;
      start_raw  = 1'b0;
      case (state_q)
         M_IDLE: begin
            cnt_d = '0;
            if (mem_req) begin
               start_raw  = 1'b1;
               freeze_raw = 1'b1;
               cnt_d      = LOAD;
               state_d    = M_WAIT;
            end
         end
         M_WAIT: begin
            freeze_raw = 1'b1;
            if (mem_ready) begin
               state_d = M_DONE;
            end else if ((WAIT_MAX != 0) && (cnt_q == '0)) begin
               timeout_d = 1'b1;
               state_d   = M_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         M_DONE: begin
            cnt_d   = '0;
            state_d = M_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = M_IDLE;
         end
      endcase
   end

   assign pipe_freeze = rst_n && freeze_raw;
   assign mem_start   = rst_n && start_raw;
   assign mem_timeout = timeout_q;
   assign mem_state   = state_q;
endmodule

// File: rtl/hazard_stall_controller.sv
// Hazard detection plus stall/flush/freeze arbitration for the pipeline.
// Optional MEM_PERF_EN adds saturating stall_cnt / freeze_cnt outputs.
module hazard_stall_controller import hazard_ctrl_pkg::*; #(
   parameter int REG_W    = DEF_REG_W,
   parameter int WAIT_MAX = 15,
   parameter int ZERO_IGN = 1,
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hazard_stall_controller_if.slave bus
`ifdef MEM_PERF_EN
   ,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        freeze_cnt
`endif
);
   logic pipe_freeze;
   logic raw_exe, raw_mem, haz;

   function automatic logic reg_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] r);
      return (x == r) && ((r != '0) || (ZERO_IGN == 0));
   endfunction

   always_comb begin
      raw_exe = bus.exe_wb_en &&
                (reg_match(bus.id_src1, bus.exe_dest) ||
                 (bus.id_src2_used && reg_match(bus.id_src2, bus.exe_dest)) ||
                 (bus.id_src3_used && reg_match(bus.id_src3, bus.exe_dest)));
      raw_mem = bus.mem_wb_en &&
                (reg_match(bus.id_src1, bus.mem_dest) ||
                 (bus.id_src2_used && reg_match(bus.id_src2, bus.mem_dest)) ||
                 (bus.id_src3_used && reg_match(bus.id_src3, bus.mem_dest)));
      // With forwarding on, only a load in EXE cannot be bypassed in time.
      haz = bus.forwarding_enable ? (raw_exe && bus.exe_mem_r_en) : (raw_exe || raw_mem);
   end

   assign bus.hazard_stall = rst_n && haz && !bus.branch_taken && !pipe_freeze;
   assign bus.flush_if_id  = rst_n && bus.branch_taken && !pipe_freeze;
   assign bus.pipe_freeze  = pipe_freeze;

   mem_wait_fsm #(.WAIT_MAX(WAIT_MAX)) u_mem_wait_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_req     (bus.mem_req),
      .mem_ready   (bus.mem_ready),
      .pipe_freeze (pipe_freeze),
      .mem_start   (bus.mem_start),
      .mem_timeout (bus.mem_timeout),
      .mem_state   (bus.mem_state)
   );

`ifdef MEM_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
      end
   end

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      freeze_cnt_d = freeze_cnt_q;
      if (bus.hazard_stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (pipe_freeze && (freeze_cnt_q != '1))
         freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
   end

   assign stall_cnt  = stall_cnt_q;
   assign freeze_cnt = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized bench for hazard_stall_controller against a behavioural access/hazard model.
module tb_hazard_stall_controller;
   import hazard_ctrl_pkg::*;

   localparam int REG_W    = 5;
   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 6;
   localparam int MAXC     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_stall_controller_if #(.REG_W(REG_W)) bus ();

`ifdef MEM_PERF_EN
   logic [CNT_W-1:0] stall_cnt, freeze_cnt;
`endif

   hazard_stall_controller #(
      .REG_W(REG_W), .WAIT_MAX(WAIT_MAX), .ZERO_IGN(1), .CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus)
`ifdef MEM_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .freeze_cnt (freeze_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;

   // model: phase 0 = no access, 1 = waiting on memory, 2 = completion cycle
   int m_phase = 0;
   int m_wait  = 0;
   bit m_to    = 1'b0;
   int m_scnt  = 0;
   int m_fcnt  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit reg_hit(input logic [REG_W-1:0] x, input logic [REG_W-1:0] r);
      return (x == r) && (r != 0);
   endfunction

   function automatic bit exp_haz();
      logic [REG_W-1:0] s[3];
      bit u[3];
      bit re, rm;
      s[0] = bus.id_src1; s[1] = bus.id_src2; s[2] = bus.id_src3;
      u[0] = 1'b1; u[1] = bus.id_src2_used; u[2] = bus.id_src3_used;
      re = 0; rm = 0;
      for (int i = 0; i < 3; i++) begin
         if (u[i] && reg_hit(s[i], bus.exe_dest)) re = 1;
         if (u[i] && reg_hit(s[i], bus.mem_dest)) rm = 1;
      end
      re = re && bus.exe_wb_en;
      rm = rm && bus.mem_wb_en;
      return bus.forwarding_enable ? (re && bus.exe_mem_r_en) : (re || rm);
   endfunction

   task automatic clear_inputs();
      bus.forwarding_enable = 0; bus.id_src1 = 0; bus.id_src2 = 0; bus.id_src3 = 0;
      bus.id_src2_used = 0; bus.id_src3_used = 0; bus.exe_dest = 0; bus.exe_wb_en = 0;
      bus.exe_mem_r_en = 0; bus.mem_dest = 0; bus.mem_wb_en = 0; bus.branch_taken = 0;
      bus.mem_req = 0; bus.mem_ready = 0;
   endtask

   task automatic rand_inputs();
      bus.forwarding_enable = 1'($urandom_range(0, 1));
      bus.id_src1      = REG_W'($urandom_range(0, 7));
      bus.id_src2      = REG_W'($urandom_range(0, 7));
      bus.id_src3      = REG_W'($urandom_range(0, 7));
      bus.id_src2_used = 1'($urandom_range(0, 1));
      bus.id_src3_used = 1'($urandom_range(0, 1));
      bus.exe_dest     = REG_W'($urandom_range(0, 7));
      bus.exe_wb_en    = 1'($urandom_range(0, 1));
      bus.exe_mem_r_en = 1'($urandom_range(0, 1));
      bus.mem_dest     = REG_W'($urandom_range(0, 7));
      bus.mem_wb_en    = 1'($urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 4) == 0);
      bus.mem_req      = ($urandom_range(0, 5) == 0);
      bus.mem_ready    = ($urandom_range(0, 4) == 0);
   endtask

   task automatic chk_zero(input string why);
      chk({why, ".hazard_stall"}, bus.hazard_stall, 0);
      chk({why, ".flush_if_id"},  bus.flush_if_id, 0);
      chk({why, ".pipe_freeze"},  bus.pipe_freeze, 0);
      chk({why, ".mem_start"},    bus.mem_start, 0);
      chk({why, ".mem_timeout"},  bus.mem_timeout, 0);
      chk({why, ".mem_state"},    bus.mem_state, 0);
`ifdef MEM_PERF_EN
      chk({why, ".stall_cnt"},  stall_cnt, 0);
      chk({why, ".freeze_cnt"}, freeze_cnt, 0);
`endif
   endtask

   // Called just after a falling edge with inputs applied; ends at the next falling edge.
   task automatic tick();
      bit fz, st, fl, sp;
      int ph;
      #1;
      fz = (m_phase == 0 && bus.mem_req) || (m_phase == 1);
      sp = (m_phase == 0 && bus.mem_req);
      st = exp_haz() && !bus.branch_taken && !fz;
      fl = bus.branch_taken && !fz;
      chk("hazard_stall", bus.hazard_stall, st);
      chk("flush_if_id",  bus.flush_if_id, fl);
      chk("pipe_freeze",  bus.pipe_freeze, fz);
      chk("mem_start",    bus.mem_start, sp);
      chk("mem_timeout",  bus.mem_timeout, m_to);
      chk("mem_state",    bus.mem_state, m_phase);
`ifdef MEM_PERF_EN
      chk("stall_cnt",  stall_cnt, m_scnt);
      chk("freeze_cnt", freeze_cnt, m_fcnt);
`endif
      @(posedge clk);
      if (st && m_scnt < MAXC) m_scnt++;
      if (fz && m_fcnt < MAXC) m_fcnt++;
      ph = m_phase;
      if (ph == 0) begin
         if (bus.mem_req) begin m_phase = 1; m_wait = 0; end
      end else if (ph == 1) begin
         m_wait++;
         if (bus.mem_ready) m_phase = 2;
         else if (WAIT_MAX != 0 && m_wait == WAIT_MAX) begin m_to = 1; m_phase = 2; end
      end else begin
         m_phase = 0; m_wait = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_zero("reset_async");
      m_phase = 0; m_wait = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_inputs();
      #2;
      chk_zero("reset_init");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // load-use with forwarding, then the same dependency on a non-load
      bus.forwarding_enable = 1; bus.exe_wb_en = 1; bus.exe_mem_r_en = 1;
      bus.exe_dest = 3; bus.id_src1 = 3;
      tick();
      bus.exe_mem_r_en = 0;
      tick();

      // forwarding off: MEM-stage dependency through src3, gated by its used bit and by r0
      clear_inputs();
      bus.mem_dest = 4; bus.mem_wb_en = 1; bus.id_src1 = 1; bus.id_src3 = 4; bus.id_src3_used = 1;
      tick();
      bus.id_src3_used = 0;
      tick();
      bus.id_src3_used = 1; bus.id_src3 = 0; bus.mem_dest = 0;
      tick();

      // access with ready on the third wait cycle, branch + hazard pending throughout
      clear_inputs();
      bus.exe_wb_en = 1; bus.exe_dest = 2; bus.id_src1 = 2; bus.branch_taken = 1;
      bus.mem_req = 1;
      tick();
      bus.mem_req = 0;
      tick(); tick();
      bus.mem_ready = 1;
      tick();
      bus.mem_ready = 0;
      tick(); tick();

      // no ready: timeout after WAIT_MAX wait cycles, stays set across a later access
      clear_inputs();
      bus.mem_req = 1;
      tick();
      bus.mem_req = 0;
      repeat (WAIT_MAX + 3) tick();
      bus.mem_req = 1;
      tick();
      bus.mem_req = 0; bus.mem_ready = 1;
      tick(); tick(); tick();

      // ready arriving exactly in the last allowed wait cycle
      clear_inputs();
      do_reset();
      bus.mem_req = 1;
      tick();
      bus.mem_req = 0;
      repeat (WAIT_MAX - 1) tick();
      bus.mem_ready = 1;
      tick();
      bus.mem_ready = 0;
      tick(); tick();

      // reset in the middle of a wait with requests and hazards still asserted
      bus.mem_req = 1;
      tick(); tick(); tick();
      bus.exe_wb_en = 1; bus.exe_dest = 5; bus.id_src1 = 5;
      do_reset();
      clear_inputs();
      tick();

      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         if (i == 1500) do_reset();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
